// File: rtl/sum_dp_controller.sv
// rtl/sum_dp_controller.sv - Control FSM sequencing the A/Sum accumulate datapath
//
// Purpose: drives the datapath control strobes so the datapath computes
//          Sum = 0+1+...+(N-1), with start/busy/done handshake, per-run limit
//          latch, abort, and a cross-check of the datapath comparator against
//          an internal iteration counter.
// Optional feature: define SUM_DP_CYC_CNT_EN to add the cyc_cnt output.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           run request (only sampled in IDLE)
//   limit           iteration count N, latched on accepted start
//   abort           cancel a run in progress
//   ALtN            datapath comparator result (A < lim_out)
//   lim_out         latched N, comparator operand
//   AsrcSel, ALoad  A mux select (0: zero, 1: A+1) and load enable
//   SumSrcSel,
//   SumLoad         Sum mux select (0: zero, 1: Sum+A) and load enable
//   OutBufSel       Sum tri-state output buffer enable
//   busy, done      not-IDLE flag, one-cycle completion pulse
//   err             sticky comparator/iteration mismatch flag
//   cyc_cnt         (SUM_DP_CYC_CNT_EN only) cycles spent in the last run

module sum_dp_controller #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             abort,
    input  logic             ALtN,
    output logic [WIDTH-1:0] lim_out,
    output logic             AsrcSel,
    output logic             ALoad,
    output logic             SumSrcSel,
    output logic             SumLoad,
    output logic             OutBufSel,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef SUM_DP_CYC_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_CMP  = 3'd2,
        S_ADD  = 3'd3,
        S_INC  = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_lim;
    logic [WIDTH:0]   r_iter;
    logic             r_err;
    logic             w_start_acc;
    logic             w_abort_acc;
    logic             w_iter_ge;
    logic             w_chk_err;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_abort_acc = (r_state != S_IDLE) && abort;
    // One extra counter bit so iter can reach lim_out even when N is all-ones.
    assign w_iter_ge   = (r_iter >= {1'b0, r_lim});
    // Comparator disagrees with the iteration count in either direction.
    assign w_chk_err   = (r_state == S_CMP) && (ALtN ? w_iter_ge : !w_iter_ge);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lim   <= '0;
            r_iter  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_acc) begin
                r_lim <= limit;
                r_err <= 1'b0;
            end else if (w_chk_err && !w_abort_acc) begin
                r_err <= 1'b1;
            end
            if (r_state == S_INIT) begin
                r_iter <= '0;
            end else if (r_state == S_INC) begin
                r_iter <= r_iter + 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        AsrcSel   = 1'b0;
        ALoad     = 1'b0;
        SumSrcSel = 1'b0;
        SumLoad   = 1'b0;
        OutBufSel = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_INIT;
            end
            S_INIT: begin
                ALoad   = 1'b1;
                SumLoad = 1'b1;
                w_next  = S_CMP;
            end
            S_CMP: begin
                // A "continue" from the comparator is overridden once the
                // iteration count says the run is already complete.
                if (ALtN && !w_iter_ge) w_next = S_ADD;
                else                    w_next = S_OUT;
            end
            S_ADD: begin
                SumSrcSel = 1'b1;
                SumLoad   = 1'b1;
                w_next    = S_INC;
            end
            S_INC: begin
                AsrcSel = 1'b1;
                ALoad   = 1'b1;
                w_next  = S_CMP;
            end
            S_OUT: begin
                OutBufSel = 1'b1;
                done      = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort_acc) w_next = S_IDLE;
    end

    assign busy    = (r_state != S_IDLE);
    assign lim_out = r_lim;
    assign err     = r_err;

`ifdef SUM_DP_CYC_CNT_EN
    logic [CNT_W-1:0] r_cyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc <= '0;
        end else if (w_start_acc) begin
            r_cyc <= '0;
        end else if (busy && (r_cyc != {CNT_W{1'b1}})) begin
            r_cyc <= r_cyc + 1'b1;
        end
    end

    assign cyc_cnt = r_cyc;
`endif

endmodule

// File: tb/tb_sum_dp_controller.sv
// tb/tb_sum_dp_controller.sv - Self-checking bench for sum_dp_controller
module tb_sum_dp_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] limit = 8'd0;
    logic       abort = 1'b0;
    logic       ALtN;
    logic [7:0] lim_out;
    logic       AsrcSel, ALoad, SumSrcSel, SumLoad, OutBufSel, busy, done, err;
`ifdef SUM_DP_CYC_CNT_EN
    logic [15:0] cyc_cnt;
`endif

    always #5 clk = ~clk;

    sum_dp_controller #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .limit(limit), .abort(abort),
        .ALtN(ALtN), .lim_out(lim_out), .AsrcSel(AsrcSel), .ALoad(ALoad),
        .SumSrcSel(SumSrcSel), .SumLoad(SumLoad), .OutBufSel(OutBufSel),
        .busy(busy), .done(done), .err(err)
`ifdef SUM_DP_CYC_CNT_EN
        , .cyc_cnt(cyc_cnt)
`endif
    );

    // Datapath model: A/Sum registers, adders, comparator, output buffer.
    logic [15:0] dp_a = 16'd0;
    logic [15:0] dp_sum = 16'd0;
    logic        stuck = 1'b0;
    logic [15:0] sum_bus;

    assign ALtN    = stuck ? 1'b1 : (dp_a < {8'd0, lim_out});
    assign sum_bus = OutBufSel ? dp_sum : 16'd0;

    always @(posedge clk) begin
        if (ALoad)   dp_a   <= AsrcSel ? dp_a + 16'd1 : 16'd0;
        if (SumLoad) dp_sum <= SumSrcSel ? dp_sum + dp_a : 16'd0;
    end

    // Behavioural model: m_t counts edges since the accepted start (0 = idle).
    // Run length is 3N+3 cycles: INIT, N x (CMP,ADD,INC), CMP, OUT.
    int          m_t = 0;
    int          m_n = 0;
    logic [7:0]  m_lim = 8'd0;
    logic        m_err = 1'b0;
    int          m_cyc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t   <= 0;
            m_lim <= 8'd0;
            m_err <= 1'b0;
            m_cyc <= 0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t   <= 1;
                m_n   <= int'(limit);
                m_lim <= limit;
                m_err <= 1'b0;
                m_cyc <= 0;
            end
        end else begin
            if (m_cyc < 65535) m_cyc <= m_cyc + 1;
            if (abort) begin
                m_t <= 0;
            end else begin
                m_t <= (m_t == 3 * m_n + 3) ? 0 : m_t + 1;
                if (stuck && m_t == 3 * m_n + 2) m_err <= 1'b1;
            end
        end
    end

    // Expected strobes {AsrcSel,ALoad,SumSrcSel,SumLoad,OutBufSel,busy,done}
    function automatic logic [6:0] exp_strobes(input int t, input int n);
        if (t == 0)             return 7'b0000000;
        if (t == 1)             return 7'b0101010;
        if (t == 3 * n + 3)     return 7'b0000111;
        case ((t - 2) % 3)
            0:       return 7'b0000010;
            1:       return 7'b0011010;
            default: return 7'b1100010;
        endcase
    endfunction

    int n_cmp = 0;
    int n_bad = 0;
    int last_sum = -1;
    int last_lat = -1;
    int n_done = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check("strobes", int'({AsrcSel, ALoad, SumSrcSel, SumLoad, OutBufSel, busy, done}),
              int'(exp_strobes(m_t, m_n)));
        check("err", int'(err), int'(m_err));
        check("lim_out", int'(lim_out), int'(m_lim));
`ifdef SUM_DP_CYC_CNT_EN
        check("cyc_cnt", int'(cyc_cnt), m_cyc);
`endif
        if (OutBufSel) begin
            check("sum_bus", int'(sum_bus), m_n * (m_n - 1) / 2);
            last_sum = int'(sum_bus);
        end
        if (done) begin
            n_done++;
            last_lat = m_t - 1;
        end
    end

    task automatic start_run(input int n);
        @(negedge clk);
        start = 1'b1;
        limit = 8'(n);
        @(negedge clk);
        start = 1'b0;
        limit = 8'd0;
    endtask

    task automatic wait_t(input int t);
        int k;
        for (k = 0; k < 2000 && m_t != t; k++) @(negedge clk);
        if (m_t != t) check("wait_t_timeout", m_t, t);
    endtask

    task automatic run_done(input int n);
        last_sum = -1;
        last_lat = -1;
        start_run(n);
        wait_t(0);
        @(negedge clk);
    endtask

    int d0;

    initial begin
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_lim_out", int'(lim_out), 0);
        check("rst_err", int'(err), 0);
        check("rst_strobes", int'({AsrcSel, ALoad, SumSrcSel, SumLoad, OutBufSel, done}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // N=10: 45 after 32 edges
        run_done(10);
        check("n10_sum", last_sum, 45);
        check("n10_lat", last_lat, 32);
        check("n10_err", int'(err), 0);
`ifdef SUM_DP_CYC_CNT_EN
        check("n10_cyc", int'(cyc_cnt), 33);
`endif

        // N=0: INIT, CMP, OUT
        run_done(0);
        check("n0_sum", last_sum, 0);
        check("n0_lat", last_lat, 2);

        // Start while busy ignored, limit change ignored
        start_run(3);
        wait_t(5);
        start = 1'b1;
        limit = 8'd7;
        @(negedge clk);
        start = 1'b0;
        limit = 8'd0;
        wait_t(0);
        check("busy_start_sum", last_sum, 3);
        check("busy_start_lim", int'(lim_out), 3);

        // Abort in third INC (t=10), no done
        d0 = n_done;
        start_run(5);
        wait_t(10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_no_done", n_done - d0, 0);
        run_done(2);
        check("after_abort_sum", last_sum, 1);

        // Comparator stuck at 1 with N=4
        stuck = 1'b1;
        run_done(4);
        stuck = 1'b0;
        check("stuck_err", int'(err), 1);
        check("stuck_sum", last_sum, 6);
        check("stuck_lat", last_lat, 14);
        repeat (3) @(negedge clk);
        check("stuck_err_hold", int'(err), 1);
        run_done(1);
        check("err_cleared", int'(err), 0);
        check("n1_sum", last_sum, 0);

        // Asynchronous reset in ADD (t=6)
        d0 = n_done;
        start_run(10);
        wait_t(6);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_strobes", int'({AsrcSel, ALoad, SumSrcSel, SumLoad, OutBufSel, done}), 0);
        @(negedge clk);
        rst = 1'b0;
        check("arst_no_done", n_done - d0, 0);
        run_done(3);
        check("arst_rerun_sum", last_sum, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
